// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: time-multiplexed hex 7-segment scanner with frame-buffered display data.
// Define FND_LZ_SUPPRESS_EN to blank leading-zero digits (digit 0 is always shown).
module fnd_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD           = 16,
  parameter int ANODE_TYPE     = 0,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] value_i,
  input  logic [DIGITS-1:0]   dot_i,
  input  logic [DIGITS-1:0]   blank_i,
  output logic [7:0]          segment_o,
  output logic [DIGITS-1:0]   digit_sel_o,
  output logic                frame_done_o
);

  localparam int CNTW = $clog2(SCAN_DIV);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] SEG_OFF = (ANODE_TYPE != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] pendVal_q, pendVal_d, actVal_q, actVal_d;
  logic [DIGITS-1:0]   pendDot_q, pendDot_d, actDot_q, actDot_d;
  logic [DIGITS-1:0]   pendBlank_q, pendBlank_d, actBlank_q, actBlank_d;
  logic [7:0]          segment_q, segment_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                frameDone_q;
  logic                slotEnd, frameEnd, inDead, suppress;
  logic [3:0]          nib;
  logic                dotBit, blankBit;
  logic [7:0]          segCath;
  logic [DIGITS-1:0]   selOneHot;

  assign slotEnd  = (cnt_q == CNTW'(SCAN_DIV - 1));
  assign frameEnd = slotEnd && (idx_q == IDXW'(DIGITS - 1));

  generate
    if (DEAD == 0) begin : gNoDead
      assign inDead = 1'b0;
    end else begin : gDead
      assign inDead = (cnt_q < CNTW'(DEAD));
    end
  endgenerate

  function automatic logic [6:0] hexDecode(input logic [3:0] n);
    case (n)
      4'h0: hexDecode = 7'h3F;
      4'h1: hexDecode = 7'h06;
      4'h2: hexDecode = 7'h5B;
      4'h3: hexDecode = 7'h4F;
      4'h4: hexDecode = 7'h66;
      4'h5: hexDecode = 7'h6D;
      4'h6: hexDecode = 7'h7D;
      4'h7: hexDecode = 7'h07;
      4'h8: hexDecode = 7'h7F;
      4'h9: hexDecode = 7'h67;
      4'hA: hexDecode = 7'h77;
      4'hB: hexDecode = 7'h7C;
      4'hC: hexDecode = 7'h39;
      4'hD: hexDecode = 7'h5E;
      4'hE: hexDecode = 7'h79;
      default: hexDecode = 7'h71;
    endcase
  endfunction

  // Scan position plus double buffering: the active copy only changes at a frame boundary,
  // taking a same-cycle load directly so the newest data is never lost.
  always_comb begin
    cnt_d       = cnt_q + CNTW'(1);
    idx_d       = idx_q;
    pendVal_d   = pendVal_q;
    pendDot_d   = pendDot_q;
    pendBlank_d = pendBlank_q;
    actVal_d    = actVal_q;
    actDot_d    = actDot_q;
    actBlank_d  = actBlank_q;
    if (slotEnd) begin
      cnt_d = '0;
      idx_d = (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + IDXW'(1);
    end
    if (load_i) begin
      pendVal_d   = value_i;
      pendDot_d   = dot_i;
      pendBlank_d = blank_i;
    end
    if (frameEnd) begin
      actVal_d   = load_i ? value_i : pendVal_q;
      actDot_d   = load_i ? dot_i   : pendDot_q;
      actBlank_d = load_i ? blank_i : pendBlank_q;
    end
  end

`ifdef FND_LZ_SUPPRESS_EN
  logic nzAcc;

  always_comb begin
    nzAcc    = 1'b0;
    suppress = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nzAcc = nzAcc | (actVal_q[4*i +: 4] != 4'h0);
      if ((i != 0) && (idx_q == IDXW'(i)) && !nzAcc) suppress = 1'b1;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  // Segment pattern is built in cathode form and inverted once at the end for anode boards.
  always_comb begin
    nib       = 4'h0;
    dotBit    = 1'b0;
    blankBit  = 1'b0;
    selOneHot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        nib          = actVal_q[4*i +: 4];
        dotBit       = actDot_q[i];
        blankBit     = actBlank_q[i];
        selOneHot[i] = 1'b1;
      end
    end
    segCath = {dotBit, suppress ? 7'h00 : hexDecode(nib)};
    if (blankBit) segCath = 8'h00;
    if (inDead) begin
      segCath   = 8'h00;
      selOneHot = '0;
    end
    segment_d = segCath ^ SEG_OFF;
    sel_d     = selOneHot ^ SEL_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pendVal_q   <= '0;
      pendDot_q   <= '0;
      pendBlank_q <= '0;
      actVal_q    <= '0;
      actDot_q    <= '0;
      actBlank_q  <= '0;
      segment_q   <= SEG_OFF;
      sel_q       <= SEL_OFF;
      frameDone_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pendVal_q   <= pendVal_d;
      pendDot_q   <= pendDot_d;
      pendBlank_q <= pendBlank_d;
      actVal_q    <= actVal_d;
      actDot_q    <= actDot_d;
      actBlank_q  <= actBlank_d;
      segment_q   <= segment_d;
      sel_q       <= sel_d;
      frameDone_q <= frameEnd;
    end
  end

  assign segment_o    = segment_q;
  assign digit_sel_o  = sel_q;
  assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver: directed checks of fnd_scan_driver in cathode, anode and single-digit builds.
// Expected digit patterns follow FND_LZ_SUPPRESS_EN when it is defined.
module tb_fnd_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dot;
  logic [3:0]  blank;

  logic [7:0]  seg, segA, seg1;
  logic [3:0]  sel, selA;
  logic [0:0]  sel1;
  logic        fd, fdA, fd1;

  int testsRun    = 0;
  int testsFailed = 0;

`ifdef FND_LZ_SUPPRESS_EN
  localparam logic [31:0] EXP_ZERO = 32'h0000003F;
  localparam logic [31:0] EXP_0008 = 32'h000000FF;
  localparam logic [31:0] EXP_0050 = 32'h00806D3F;
`else
  localparam logic [31:0] EXP_ZERO = 32'h3F3F3F3F;
  localparam logic [31:0] EXP_0008 = 32'h3F3F3FFF;
  localparam logic [31:0] EXP_0050 = 32'h3FBF6D3F;
`endif

  always #5 clk = ~clk;

  fnd_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .DEAD(2), .ANODE_TYPE(0), .SEL_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load), .value_i(value), .dot_i(dot), .blank_i(blank),
    .segment_o(seg), .digit_sel_o(sel), .frame_done_o(fd)
  );

  fnd_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .DEAD(2), .ANODE_TYPE(1), .SEL_ACTIVE_LOW(0)) dutA (
    .clk(clk), .rst_n(rst_n), .load_i(load), .value_i(value), .dot_i(dot), .blank_i(blank),
    .segment_o(segA), .digit_sel_o(selA), .frame_done_o(fdA)
  );

  fnd_scan_driver #(.DIGITS(1), .SCAN_DIV(4), .DEAD(0), .ANODE_TYPE(0), .SEL_ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_i(load), .value_i(value[3:0]), .dot_i(dot[0:0]),
    .blank_i(blank[0:0]), .segment_o(seg1), .digit_sel_o(sel1), .frame_done_o(fd1)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    value = 16'h0;
    dot   = 4'h0;
    blank = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    testsRun++;
    if ({seg, sel, fd} !== {8'h00, 4'hF, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_main got %h exp %h", {seg, sel, fd}, {8'h00, 4'hF, 1'b0});
    end
    testsRun++;
    if ({segA, selA, fdA} !== {8'hFF, 4'h0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_anode got %h exp %h", {segA, selA, fdA}, {8'hFF, 4'h0, 1'b0});
    end
    testsRun++;
    if ({seg1, sel1, fd1} !== {8'h00, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_single got %h exp %h", {seg1, sel1, fd1}, {8'h00, 1'b1, 1'b0});
    end
  endtask

  // Releases reset on a falling edge and checks the two dead cycles and first lit cycle.
  task automatic test_first_lit();
    logic [12:0] eMain, eAnode;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      eMain  = (k <= 2) ? {8'h00, 4'hF, 1'b0} : {8'h3F, 4'hE, 1'b0};
      eAnode = (k <= 2) ? {8'hFF, 4'h0, 1'b0} : {8'hC0, 4'h1, 1'b0};
      testsRun++;
      if ({seg, sel, fd} !== eMain) begin
        testsFailed++;
        $display("[TB] FAIL first_lit_main k=%0d got %h exp %h", k, {seg, sel, fd}, eMain);
      end
      testsRun++;
      if ({segA, selA, fdA} !== eAnode) begin
        testsFailed++;
        $display("[TB] FAIL first_lit_anode k=%0d got %h exp %h", k, {segA, selA, fdA}, eAnode);
      end
      testsRun++;
      if ({seg1, sel1, fd1} !== {8'h3F, 1'b0, 1'b0}) begin
        testsFailed++;
        $display("[TB] FAIL first_lit_single k=%0d got %h exp %h", k, {seg1, sel1, fd1},
                 {8'h3F, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!fd && n < 100);
    testsRun++;
    if (fd !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL frame_sync got frame_done=%b exp 1 within 100 cycles", fd);
    end
  endtask

  // Checks one full 32-cycle frame; expMain holds the cathode digit bytes {d3,d2,d1,d0}.
  // Optionally loads v1 at cycle loadAt and v2 the cycle after.
  task automatic test_frame(input string tag, input logic [31:0] expMain, input bit chkSingle,
                            input int loadAt, input logic [15:0] v1, input logic [15:0] v2,
                            input logic [3:0] d, input logic [3:0] b);
    int cnt, idx;
    bit dead;
    logic [7:0] eSeg;
    logic [3:0] eSel, eSelA;
    logic eFd;
    for (int j = 0; j < 32; j++) begin
      @(posedge clk);
      @(negedge clk);
      cnt   = j % 8;
      idx   = j / 8;
      dead  = (cnt < 2);
      eSeg  = dead ? 8'h00 : expMain[idx*8 +: 8];
      eSel  = dead ? 4'hF : ~(4'b0001 << idx);
      eSelA = dead ? 4'h0 : (4'b0001 << idx);
      eFd   = (j == 31);
      testsRun++;
      if ({seg, sel, fd} !== {eSeg, eSel, eFd}) begin
        testsFailed++;
        $display("[TB] FAIL %s_main j=%0d got %h exp %h", tag, j, {seg, sel, fd}, {eSeg, eSel, eFd});
      end
      testsRun++;
      if ({segA, selA, fdA} !== {~eSeg, eSelA, eFd}) begin
        testsFailed++;
        $display("[TB] FAIL %s_anode j=%0d got %h exp %h", tag, j, {segA, selA, fdA},
                 {~eSeg, eSelA, eFd});
      end
      if (chkSingle) begin
        testsRun++;
        if ({seg1, sel1, fd1} !== {expMain[7:0], 1'b0, (j % 4) == 3}) begin
          testsFailed++;
          $display("[TB] FAIL %s_single j=%0d got %h exp %h", tag, j, {seg1, sel1, fd1},
                   {expMain[7:0], 1'b0, (j % 4) == 3});
        end
      end
      if (j == loadAt) begin
        load  = 1'b1;
        value = v1;
        dot   = d;
        blank = b;
      end else if (j == loadAt + 1 && v2 != v1) begin
        load  = 1'b1;
        value = v2;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
  endtask

  // Reset-state frame; 0x1234 is loaded on the boundary cycle itself, bypassing the pending copy.
  task automatic test_idle_zero();
    test_frame("zero", EXP_ZERO, 1'b1, 30, 16'h1234, 16'h1234, 4'h0, 4'h0);
  endtask

  task automatic test_no_tearing();
    test_frame("v1234", 32'h065B4F66, 1'b0, 5, 16'hABCD, 16'h5555, 4'h0, 4'h0);
  endtask

  task automatic test_last_load_wins();
    test_frame("v5555", 32'h6D6D6D6D, 1'b1, 30, 16'h0008, 16'h0008, 4'b0001, 4'h0);
  endtask

  task automatic test_anode_dp();
    test_frame("v0008", EXP_0008, 1'b1, 30, 16'h1234, 16'h1234, 4'h0, 4'b0100);
  endtask

  task automatic test_blank();
    test_frame("blank", 32'h06004F66, 1'b1, 30, 16'h0050, 16'h0050, 4'b0100, 4'h0);
  endtask

  task automatic test_leading_zero();
    test_frame("v0050", EXP_0050, 1'b1, -1, 16'h0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic test_reset_mid();
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    testsRun++;
    if ({seg, sel, fd} !== {8'h00, 4'hF, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset_main got %h exp %h", {seg, sel, fd}, {8'h00, 4'hF, 1'b0});
    end
    testsRun++;
    if ({segA, selA, fdA} !== {8'hFF, 4'h0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset_anode got %h exp %h", {segA, selA, fdA}, {8'hFF, 4'h0, 1'b0});
    end
    testsRun++;
    if ({seg1, sel1, fd1} !== {8'h00, 1'b1, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset_single got %h exp %h", {seg1, sel1, fd1}, {8'h00, 1'b1, 1'b0});
    end
    repeat (2) @(posedge clk);
    test_first_lit();
    wait_frame();
    test_frame("post_reset", EXP_ZERO, 1'b1, -1, 16'h0, 16'h0, 4'h0, 4'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_first_lit();
    wait_frame();
    test_idle_zero();
    test_no_tearing();
    test_last_load_wins();
    test_anode_dp();
    test_blank();
    test_leading_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
